// File: rtl/sdr_arbiter.sv
// Round-robin arbiter sharing one avalon_sdr transfer engine among NREQ requesters.
// Latches the granted job, launches the engine, and captures read results.
module sdr_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned MAX_NREAD  = 64,
    parameter int unsigned MAX_NWRITE = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ-1:0]              req_write,
    input  logic [32*NREQ-1:0]           req_addr,
    input  logic [30*NREQ-1:0]           req_nelems,
    input  logic [32*MAX_NWRITE*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]              req_ack,
    output logic [NREQ-1:0]              req_done,
    output logic                         req_err,
    output logic [32*MAX_NREAD-1:0]      rd_data,
    output logic                         busy,
    output logic [31:0]                  sdr_baseaddr,
    output logic [29:0]                  sdr_nelems,
    output logic [32*MAX_NWRITE-1:0]     sdr_writedata,
    output logic                         sdr_readstart,
    output logic                         sdr_writestart,
    input  logic                         sdr_readend,
    input  logic                         sdr_writeend,
    input  logic [32*MAX_NREAD-1:0]      sdr_readdata
);

    localparam int unsigned GW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned RDW = 32 * MAX_NREAD;
    localparam int unsigned WDW = 32 * MAX_NWRITE;
    localparam logic [29:0] MAX_RD = 30'(MAX_NREAD);
    localparam logic [29:0] MAX_WR = 30'(MAX_NWRITE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_BUSY,
        S_DONE,
        S_REJECT
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [31:0]     job_addr_q, job_addr_d;
    logic [29:0]     job_nelems_q, job_nelems_d;
    logic            job_write_q, job_write_d;
    logic [WDW-1:0]  job_wdata_q, job_wdata_d;
    logic [RDW-1:0]  rd_data_q, rd_data_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            rstart_q, rstart_d;
    logic            wstart_q, wstart_d;

    logic [31:0]     addr_arr   [NREQ];
    logic [29:0]     nelems_arr [NREQ];
    logic [WDW-1:0]  wdata_arr  [NREQ];

    logic            win_found;
    logic [GW-1:0]   win;
    logic            win_legal;
    logic [NREQ-1:0] grant_oh;

    // Reshape the flat request buses into per-requester arrays.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i]   = req_addr[32*i +: 32];
        assign nelems_arr[i] = req_nelems[30*i +: 30];
        assign wdata_arr[i]  = req_wdata[WDW*i +: WDW];
    end

    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int unsigned k);
        return GW'((32'(base) + k) % NREQ);
    endfunction

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        win_found = 1'b0;
        win       = last_grant_q;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!win_found && req_valid[rr_idx(last_grant_q, k)]) begin
                win_found = 1'b1;
                win       = rr_idx(last_grant_q, k);
            end
        end
        win_legal = (nelems_arr[win] != 30'd0) &&
                    (req_write[win] ? (nelems_arr[win] <= MAX_WR) : (nelems_arr[win] <= MAX_RD));
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        job_addr_d   = job_addr_q;
        job_nelems_d = job_nelems_q;
        job_write_d  = job_write_q;
        job_wdata_d  = job_wdata_q;
        rd_data_d    = rd_data_q;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    last_grant_d = win;
                    job_addr_d   = addr_arr[win];
                    job_nelems_d = nelems_arr[win];
                    job_write_d  = req_write[win];
                    job_wdata_d  = wdata_arr[win];
                    state_d      = win_legal ? S_LAUNCH : S_REJECT;
                end
            end
            S_LAUNCH: state_d = S_BUSY;
            S_BUSY: begin
                // Only the end pulse matching the job type completes it.
                if (job_write_q ? sdr_writeend : sdr_readend) begin
                    state_d = S_DONE;
                    if (!job_write_q) begin
                        rd_data_d = sdr_readdata;
                    end
                end
            end
            S_DONE:   state_d = S_IDLE;
            S_REJECT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Pulses are decoded from the next state so they line up with it once registered.
        grant_oh = NREQ'(1) << last_grant_d;
        ack_d    = (state_d == S_LAUNCH || state_d == S_REJECT) ? grant_oh : '0;
        done_d   = (state_d == S_DONE   || state_d == S_REJECT) ? grant_oh : '0;
        err_d    = (state_d == S_REJECT);
        busy_d   = (state_d != S_IDLE);
        rstart_d = (state_d == S_LAUNCH) && !job_write_d;
        wstart_d = (state_d == S_LAUNCH) &&  job_write_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= GW'(NREQ - 1);
            job_addr_q   <= '0;
            job_nelems_q <= '0;
            job_write_q  <= 1'b0;
            job_wdata_q  <= '0;
            rd_data_q    <= '0;
            ack_q        <= '0;
            done_q       <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            rstart_q     <= 1'b0;
            wstart_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            job_addr_q   <= job_addr_d;
            job_nelems_q <= job_nelems_d;
            job_write_q  <= job_write_d;
            job_wdata_q  <= job_wdata_d;
            rd_data_q    <= rd_data_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            rstart_q     <= rstart_d;
            wstart_q     <= wstart_d;
        end
    end

    assign req_ack        = ack_q;
    assign req_done       = done_q;
    assign req_err        = err_q;
    assign rd_data        = rd_data_q;
    assign busy           = busy_q;
    assign sdr_baseaddr   = job_addr_q;
    assign sdr_nelems     = job_nelems_q;
    assign sdr_writedata  = job_wdata_q;
    assign sdr_readstart  = rstart_q;
    assign sdr_writestart = wstart_q;

endmodule

// File: doc/sdr_arbiter.md
# sdr_arbiter

Round-robin arbiter that shares a single `avalon_sdr` transfer engine among `NREQ` requesters (ray cores, framebuffer writer, scene loader). Each requester posts a read or write job (base address, element count, write payload); the arbiter grants one job at a time and latches its fields for the whole transfer. It launches the engine with a one-cycle start pulse and captures read results into a stable output buffer. Jobs with illegal lengths are rejected without touching the engine.

## Interface

Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `MAX_NREAD`, 64: engine read capacity in 32-bit elements.
- `MAX_NWRITE`, 64: engine write capacity in 32-bit elements.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `req_valid`  in  NREQ  job pending per requester; hold until matching `req_ack`.
- `req_write`  in  NREQ  1 = write job, 0 = read job.
- `req_addr`  in  32*NREQ  byte base address, slice i = `[32*i +: 32]`.
- `req_nelems`  in  30*NREQ  32-bit element count, slice i = `[30*i +: 30]`.
- `req_wdata`  in  32*MAX_NWRITE*NREQ  write payload, slice i = `[32*MAX_NWRITE*i +: 32*MAX_NWRITE]`.
- `req_ack`  out  NREQ  one-cycle pulse: job i accepted, fields sampled.
- `req_done`  out  NREQ  one-cycle pulse: job i finished.
- `req_err`  out  1  valid with any `req_done`; 1 = job rejected.
- `rd_data`  out  32*MAX_NREAD  last completed read result.
- `busy`  out  1  high in any state except IDLE.
- `sdr_baseaddr`  out  32  to engine.
- `sdr_nelems`  out  30  to engine.
- `sdr_writedata`  out  32*MAX_NWRITE  to engine.
- `sdr_readstart`, `sdr_writestart`  out  1  engine start pulses.
- `sdr_readend`, `sdr_writeend`  in  1  engine completion pulses.
- `sdr_readdata`  in  32*MAX_NREAD  engine read buffer.

## Operation

- States: IDLE, LAUNCH, BUSY, DONE, REJECT.
- IDLE: if any `req_valid`, pick winner g by searching from `last_grant+1` mod NREQ upward with wrap. At the edge, latch g's addr, nelems, write flag and wdata into the job registers, set `last_grant <= g`, and compute legality.
  - Illegal: nelems==0, or nelems > MAX_NREAD (read), or nelems > MAX_NWRITE (write).
  - Legal goes to LAUNCH; illegal goes to REJECT.
- LAUNCH: `req_ack[g]`=1; assert exactly one of `sdr_readstart`/`sdr_writestart` per the latched write flag. Go to BUSY.
- BUSY: wait for the end pulse matching the job type; the other end pulse is ignored.
  - On `sdr_readend`, copy `sdr_readdata` into `rd_data` at that edge.
  - Go to DONE.
- DONE: `req_done[g]`=1, `req_err`=0. Go to IDLE.
- REJECT: `req_ack[g]`=1, `req_done[g]`=1, `req_err`=1, no engine start. Go to IDLE.
- `sdr_baseaddr`/`sdr_nelems`/`sdr_writedata` are driven from the job registers and stay constant from LAUNCH until the next grant.
- `rd_data` changes only on a read completion; writes and rejects leave it unchanged.
- End pulses arriving in IDLE/LAUNCH/DONE/REJECT are ignored.
- A requester still holding `req_valid` after its ack posts a new job; it competes normally and loses priority to the others.

## Timing

- Reset values:
  - state IDLE, `last_grant`=NREQ-1 (requester 0 wins first).
  - All pulses 0, `busy`=0, `rd_data`=0, job registers 0.
- Grant to start: `req_valid` seen in IDLE at cycle t gives `req_ack` and start at t+1.
- Completion: end pulse at cycle e gives `req_done` at e+1.
- Back-to-back: the next grant decision is made in the IDLE cycle at e+2, so the next start is at e+3 or later. This gap keeps start low while the engine is in its done state and on its return to INIT.
- Reject: `req_valid` at t gives ack+done+err together at t+1; next decision at t+2.
- Start pulses are exactly one cycle and are never asserted outside LAUNCH.
- Reset asserted mid-job: the arbiter returns to IDLE immediately with all outputs at reset values. The system resets the engine in the same window; stale end pulses after reset are ignored.

## Test plan

- Single read, requester 2, addr 0x1000, nelems 4:
  - ack[2] and readstart one cycle after valid.
  - `sdr_baseaddr`=0x1000 and `sdr_nelems`=4 held through BUSY.
  - done[2] at end+1 with `rd_data` = engine's 128 bits, `req_err`=0.
- All four requesters valid at once, held until ack: grants in order 0,1,2,3.
  - Requester 0 re-raises valid immediately: order continues 1,2,3,0, then 0 again only after the others are served.
- Write job, nelems=MAX_NWRITE:
  - writestart only.
  - `sdr_writedata` equals the requester's slice for the whole transfer, even with `req_wdata` toggled after ack.
  - `rd_data` unchanged.
- Reject cases: nelems=0, and read nelems=MAX_NREAD+1.
  - Each gives ack, done and err=1 in the same cycle.
  - No start pulse; `busy` high for exactly one cycle.
- Spurious `sdr_writeend` during a read job: ignored; completion occurs only on `sdr_readend`.
- Reset driven low during BUSY:
  - All outputs return to 0, state IDLE.
  - After release, a new job from requester 1 is granted and completes normally.
